// File: rtl/param_counter_pkg.sv
// rtl/param_counter_pkg.sv - shared constants and width helper for param_counter
package cnt_pkg;

  localparam logic CNT_UP    = 1'b1;
  localparam logic CNT_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_SAT  = 1'b1;

  // Bits needed to hold values 0..v-1; returns 0 for v <= 1.
  function automatic int clog2(input int v);
    int r;
    int x;
    r = 0;
    x = v - 1;
    while (x > 0) begin
      r = r + 1;
      x = x >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/param_counter_tick.sv
// rtl/param_counter_tick.sv - clock-enable prescaler, one tick per DIV enabled cycles
module prescaler_tick
  import cnt_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rstn,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = (clog2(DIV) < 1) ? 1 : clog2(DIV);
  localparam logic [PW-1:0] LAST = PW'(DIV - 1);

  logic [PW-1:0] pre;

  // With DIV=1 LAST is 0, so pre never leaves 0 and tick follows en.
  assign tick = en && (pre == LAST);

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      pre <= '0;
    end else if (en) begin
      pre <= (pre == LAST) ? '0 : pre + 1'b1;
    end
  end

endmodule

// File: rtl/param_counter.sv
// rtl/param_counter.sv - up/down counter with modulus, prescaler, load/clear, wrap/saturate
module param_counter
  import cnt_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int MAX   = 15,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             en,
  input  logic             up_dn,
  input  logic             sat_mode,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cnt,
  output logic             tc,
  output logic             ovf
);

  generate
    if (WIDTH < 2 || WIDTH > 32 || MAX < 1 || DIV < 1 ||
        longint'(MAX) > ((longint'(1) << WIDTH) - 1)) begin : g_bad_params
      $error("param_counter: MAX must fit in WIDTH bits and WIDTH/DIV must be in range");
    end
  endgenerate

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MAX);

  logic             step;
  logic             hit;
  logic [WIDTH-1:0] nxt;

  prescaler_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rstn (rstn),
    .en   (en),
    .clr  (clr | load),
    .tick (step)
  );

  // Boundary detect and next value for a qualifying step.
  always_comb begin
    hit = 1'b0;
    nxt = cnt;
    if (up_dn == CNT_UP) begin
      if (cnt >= MAXV) begin
        hit = 1'b1;
        nxt = (sat_mode == MODE_SAT) ? MAXV : '0;
      end else begin
        nxt = cnt + 1'b1;
      end
    end else begin
      if (cnt == '0) begin
        hit = 1'b1;
        nxt = (sat_mode == MODE_SAT) ? '0 : MAXV;
      end else begin
        nxt = cnt - 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      cnt <= '0;
      tc  <= 1'b0;
      ovf <= 1'b0;
    end else if (load) begin
      cnt <= (load_val > MAXV) ? MAXV : load_val;
      tc  <= 1'b0;
    end else if (step) begin
      cnt <= nxt;
      tc  <= hit;
      ovf <= ovf | hit;
    end else begin
      tc  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// tb/tb_param_counter.sv - three-configuration bench with vector table, directed cases and random model
module tb_param_counter;

  logic       clk = 1'b0;
  logic       rstn, en, up_dn, sat_mode, clr, load;
  logic [3:0] load_val;
  logic [3:0] cnt_a, cnt_b, cnt_c;
  logic       tc_a, tc_b, tc_c, ovf_a, ovf_b, ovf_c;

  int nchecks = 0;
  int nerr    = 0;

  always #5 clk = ~clk;

  param_counter #(.WIDTH(4), .MAX(15), .DIV(1)) u_a (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .cnt(cnt_a), .tc(tc_a), .ovf(ovf_a));
  param_counter #(.WIDTH(4), .MAX(9), .DIV(1)) u_b (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .cnt(cnt_b), .tc(tc_b), .ovf(ovf_b));
  param_counter #(.WIDTH(4), .MAX(9), .DIV(4)) u_c (
    .clk(clk), .rstn(rstn), .en(en), .up_dn(up_dn), .sat_mode(sat_mode), .clr(clr),
    .load(load), .load_val(load_val), .cnt(cnt_c), .tc(tc_c), .ovf(ovf_c));

  // Reference model: one entry per instance, stepped from the behavioural rules.
  int mx [3] = '{15, 9, 9};
  int dv [3] = '{1, 1, 4};
  int m_cnt [3];
  int m_pre [3];
  int m_tc  [3];
  int m_ovf [3];

  function automatic int act_cnt(input int k);
    return (k == 0) ? int'(cnt_a) : (k == 1) ? int'(cnt_b) : int'(cnt_c);
  endfunction
  function automatic int act_tc(input int k);
    return (k == 0) ? int'(tc_a) : (k == 1) ? int'(tc_b) : int'(tc_c);
  endfunction
  function automatic int act_ovf(input int k);
    return (k == 0) ? int'(ovf_a) : (k == 1) ? int'(ovf_b) : int'(ovf_c);
  endfunction

  task automatic check(input string name, input int act, input int exp);
    nchecks++;
    if (act != exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    for (int k = 0; k < 3; k++) begin
      if (!rstn || clr) begin
        m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0;
        m_ovf[k] = 0;
      end else if (load) begin
        m_cnt[k] = (int'(load_val) > mx[k]) ? mx[k] : int'(load_val);
        m_pre[k] = 0; m_tc[k] = 0;
      end else if (en) begin
        m_pre[k] = m_pre[k] + 1;
        m_tc[k]  = 0;
        if (m_pre[k] == dv[k]) begin
          int edge_hit;
          m_pre[k] = 0;
          edge_hit = up_dn ? (m_cnt[k] == mx[k]) : (m_cnt[k] == 0);
          if (edge_hit) begin
            m_tc[k]  = 1;
            m_ovf[k] = 1;
          end
          if (!(edge_hit && sat_mode))
            m_cnt[k] = up_dn ? (m_cnt[k] + 1) % (mx[k] + 1)
                             : (m_cnt[k] + mx[k]) % (mx[k] + 1);
        end
      end else begin
        m_tc[k] = 0;
      end
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("model[%0d].cnt", k), act_cnt(k), m_cnt[k]);
      check($sformatf("model[%0d].tc", k),  act_tc(k),  m_tc[k]);
      check($sformatf("model[%0d].ovf", k), act_ovf(k), m_ovf[k]);
    end
  endtask

  task automatic expect_dut(input string name, input int k, input int c, input int t, input int o);
    check({name, ".cnt"}, act_cnt(k), c);
    check({name, ".tc"},  act_tc(k),  t);
    check({name, ".ovf"}, act_ovf(k), o);
  endtask

  task automatic do_reset();
    rstn = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0;
    cycle();
    rstn = 1'b1;
  endtask

  typedef struct {
    logic en;
    logic up;
    logic sat;
    int   exp_cnt;
    int   exp_tc;
    int   exp_ovf;
  } vec_t;

  vec_t tbl [17];

  initial begin
    rstn = 1'b0; en = 1'b0; up_dn = 1'b1; sat_mode = 1'b0;
    clr = 1'b0; load = 1'b0; load_val = '0;
    for (int k = 0; k < 3; k++) begin
      m_cnt[k] = 0; m_pre[k] = 0; m_tc[k] = 0; m_ovf[k] = 0;
    end
    for (int i = 0; i < 17; i++)
      tbl[i] = '{en: 1'b1, up: 1'b1, sat: 1'b0, exp_cnt: (i + 1) % 16,
                 exp_tc: ((i + 1) == 16) ? 1 : 0, exp_ovf: ((i + 1) >= 16) ? 1 : 0};

    // Reset state
    do_reset();
    for (int k = 0; k < 3; k++) expect_dut($sformatf("reset[%0d]", k), k, 0, 0, 0);

    // 16-value wrap on the MAX=15 instance
    for (int i = 0; i < 17; i++) begin
      en = tbl[i].en; up_dn = tbl[i].up; sat_mode = tbl[i].sat;
      cycle();
      expect_dut($sformatf("wrap16[%0d]", i), 0, tbl[i].exp_cnt, tbl[i].exp_tc, tbl[i].exp_ovf);
    end

    // Saturate at zero going down, then wrap to MAX
    do_reset();
    en = 1'b1; up_dn = 1'b0; sat_mode = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      expect_dut($sformatf("sat_dn[%0d]", i), 1, 0, 1, 1);
    end
    sat_mode = 1'b0;
    cycle();
    expect_dut("wrap_dn", 1, 9, 1, 1);
    en = 1'b0;
    cycle();
    expect_dut("hold_dn", 1, 9, 0, 1);

    // Load clamp, load+clr, load+en
    load = 1'b1; load_val = 4'd12;
    cycle();
    expect_dut("load_clamp", 1, 9, 0, 1);
    check("load_noclamp.cnt", act_cnt(0), 12);
    clr = 1'b1; load_val = 4'd5;
    cycle();
    expect_dut("load_clr", 1, 0, 0, 0);
    clr = 1'b0; en = 1'b1; up_dn = 1'b1;
    cycle();
    expect_dut("load_en", 1, 5, 0, 0);
    load = 1'b0;

    // Prescaler period and stretch by en low
    do_reset();
    en = 1'b1; up_dn = 1'b1; sat_mode = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      cycle();
      check($sformatf("div4[%0d].cnt", i), act_cnt(2), (i >= 4) ? 1 : 0);
    end
    en = 1'b0;
    cycle(); check("div4_hold0.cnt", act_cnt(2), 1);
    cycle(); check("div4_hold1.cnt", act_cnt(2), 1);
    en = 1'b1;
    cycle(); check("div4_resume0.cnt", act_cnt(2), 1);
    cycle(); check("div4_resume1.cnt", act_cnt(2), 2);

    // Reset mid-count and mid-prescale
    en = 1'b0; load = 1'b1; load_val = 4'd0;
    cycle();
    load = 1'b0; en = 1'b1; up_dn = 1'b0;
    repeat (4) cycle();
    expect_dut("c_wrap_dn", 2, 9, 1, 1);
    en = 1'b0; load = 1'b1; load_val = 4'd7;
    cycle();
    load = 1'b0; en = 1'b1; up_dn = 1'b1;
    repeat (2) cycle();
    expect_dut("c_mid", 2, 7, 0, 1);
    rstn = 1'b0;
    cycle();
    rstn = 1'b1;
    expect_dut("c_reset", 2, 0, 0, 0);
    for (int i = 1; i <= 4; i++) begin
      cycle();
      check($sformatf("c_restart[%0d].cnt", i), act_cnt(2), (i == 4) ? 1 : 0);
    end

    // Randomized run against the model
    for (int i = 0; i < 10000; i++) begin
      rstn     = ($urandom_range(0, 255) != 0);
      clr      = ($urandom_range(0, 63) == 0);
      load     = ($urandom_range(0, 15) == 0);
      load_val = 4'($urandom_range(0, 15));
      en       = ($urandom_range(0, 3) != 0);
      up_dn    = 1'($urandom_range(0, 1));
      sat_mode = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", nerr, nchecks);
    $finish;
  end

endmodule
